// File: rtl/mem_access_unit_pkg.sv
// Shared types for the load/store initiator: bus widths, access size and FSM state.
// Also holds the alignment rule so the top and any unit bench use one definition.
package mem_access_unit_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } mau_state_t;

    // Size 2'b11 has no legal encoding and is reported as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic w_mis;
        case (size)
            2'b00:   w_mis = 1'b0;
            2'b01:   w_mis = addr_lo[0];
            2'b10:   w_mis = |addr_lo;
            default: w_mis = 1'b1;
        endcase
        return w_mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load extraction with sign/zero extension and
// sub-word store merge into a previously read memory word.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0] i_addr_lo,
    input  mem_size_t  i_size,
    input  logic       i_unsigned,
    input  data_t      i_word,
    input  data_t      i_wdata,
    output data_t      o_load_data,
    output data_t      o_store_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [4:0]  w_byte_pos;
    logic [4:0]  w_half_pos;

    assign w_byte_pos = {i_addr_lo, 3'b000};
    assign w_half_pos = {i_addr_lo[1], 4'b0000};
    assign w_byte     = i_word[w_byte_pos +: 8];
    assign w_half     = i_word[w_half_pos +: 16];

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        o_load_data = i_word;
        case (i_size)
            MEM_BYTE: o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            MEM_HALF: o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default:  o_load_data = i_word;
        endcase
    end

    always_comb begin
        o_store_word = i_word;
        case (i_size)
            MEM_BYTE: o_store_word[w_byte_pos +: 8]  = i_wdata[7:0];
            MEM_HALF: o_store_word[w_half_pos +: 16] = i_wdata[15:0];
            default:  o_store_word = i_wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding RISC-V load/store initiator for a word-addressed memory with
// combinational read; sub-word stores are done as read-modify-write.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  req_valid,
    output logic  req_ready,
    input  logic  req_write,
    input  logic [1:0] req_size,
    input  logic  req_unsigned,
    input  addr_t req_addr,
    input  data_t req_wdata,
    output logic  rsp_valid,
    output data_t rsp_rdata,
    output logic  rsp_misaligned,
    output addr_t mem_address,
    output data_t mem_write_data,
    output logic  mem_write_enable,
    input  data_t mem_read_data
);

    mau_state_t r_state;
    mau_state_t w_next_state;

    addr_t     r_addr;
    mem_size_t r_size;
    logic      r_unsigned;
    logic      r_write;
    data_t     r_wdata;
    data_t     r_buf;
    data_t     r_rsp_rdata;
    logic      r_rsp_misaligned;

    logic      w_accept;
    logic      w_misaligned;
    data_t     w_align_word;
    data_t     w_load_data;
    data_t     w_store_word;

    assign w_accept     = req_valid && (r_state == IDLE);
    assign w_misaligned = is_misaligned(req_size, req_addr[1:0]);

    // Loads extract straight from the live read; merges use the buffered word.
    assign w_align_word = (r_state == READ) ? mem_read_data : r_buf;

    mem_lane_align u_lane_align (
        .i_addr_lo    (r_addr[1:0]),
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_word       (w_align_word),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        req_ready        = 1'b0;
        rsp_valid        = 1'b0;
        mem_write_enable = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_misaligned) begin
                        w_next_state = RESP;
                    end else if (req_write && (req_size == MEM_WORD)) begin
                        w_next_state = WRITE;
                    end else begin
                        w_next_state = READ;
                    end
                end
            end
            READ: begin
                w_next_state = r_write ? WRITE : RESP;
            end
            WRITE: begin
                // Gated so that a reset landing on this cycle cannot corrupt memory.
                mem_write_enable = reset_n;
                w_next_state     = RESP;
            end
            RESP: begin
                rsp_valid    = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_addr           <= '0;
            r_size           <= MEM_BYTE;
            r_unsigned       <= 1'b0;
            r_write          <= 1'b0;
            r_wdata          <= '0;
            r_buf            <= '0;
            r_rsp_rdata      <= '0;
            r_rsp_misaligned <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr     <= req_addr;
                r_size     <= mem_size_t'(req_size);
                r_unsigned <= req_unsigned;
                r_write    <= req_write;
                r_wdata    <= req_wdata;
                if (w_misaligned) begin
                    r_rsp_rdata      <= '0;
                    r_rsp_misaligned <= 1'b1;
                end
            end
            if (r_state == READ) begin
                r_buf <= mem_read_data;
                if (!r_write) begin
                    r_rsp_rdata      <= w_load_data;
                    r_rsp_misaligned <= 1'b0;
                end
            end
            if (r_state == WRITE) begin
                r_rsp_rdata      <= '0;
                r_rsp_misaligned <= 1'b0;
            end
        end
    end

    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_misaligned = r_rsp_misaligned;
    assign mem_address    = {r_addr[31:2], 2'b00};
    assign mem_write_data = w_store_word;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset-in-WRITE
// sequence, then random traffic against a byte-array reference memory.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_misaligned   (rsp_misaligned),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    // Memory attached to the DUT: 64 words, combinational read.
    logic [31:0] tb_mem [0:63] = '{default: 32'h0};
    bit          preload_req = 1'b0;
    int          wr_count = 0;

    assign mem_read_data = tb_mem[mem_address[7:2]];

    always @(posedge clk) begin
        if (preload_req) begin
            tb_mem[4] <= 32'h8899AABB;
        end else if (mem_write_enable) begin
            tb_mem[mem_address[7:2]] <= mem_write_data;
            wr_count <= wr_count + 1;
        end
    end

    // Reference memory as plain little-endian bytes.
    logic [7:0] ref_bytes [0:255];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Behavioural model: access semantics from byte counts and byte arithmetic.
    task automatic ref_model(input bit wr, input logic [1:0] size, input bit uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output bit mis, output int lat,
                             output int wcyc, output logic [31:0] wword);
        int     n;
        int     a;
        int     base;
        longint v;
        a = int'(addr[7:0]);
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
        mis   = (n == 0) || ((a % n) != 0);
        rdata = '0;
        wword = '0;
        wcyc  = 0;
        if (mis) begin
            lat = 1;
        end else if (!wr) begin
            v = 0;
            for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(ref_bytes[a + i]);
            if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
            rdata = v[31:0];
            lat   = 2;
        end else begin
            for (int i = 0; i < n; i++) ref_bytes[a + i] = wdata[8 * i +: 8];
            lat  = (n == 4) ? 2 : 3;
            wcyc = lat - 1;
            base = a - (a % 4);
            for (int i = 0; i < 4; i++) wword[8 * i +: 8] = ref_bytes[base + i];
        end
    endtask

    task automatic run_txn(input string tag, input bit wr, input logic [1:0] size, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input bit hold,
                           input logic [31:0] exp_rdata, input bit exp_mis, input int exp_lat,
                           input int exp_wcyc, input logic [31:0] exp_wword);
        int          lat;
        int          wcyc;
        int          wr0;
        bit          seen;
        bit          mis;
        logic [31:0] wword;
        logic [31:0] waddr;
        logic [31:0] rdata;
        @(negedge clk);
        check({tag, " ready_before"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        wr0   = wr_count;
        lat   = 0;
        wcyc  = 0;
        seen  = 1'b0;
        mis   = 1'b0;
        wword = '0;
        waddr = '0;
        rdata = '0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clk);
            if (mem_write_enable && wcyc == 0) begin
                wcyc  = c;
                wword = mem_write_data;
                waddr = mem_address;
            end
            if (rsp_valid) begin
                seen      = 1'b1;
                lat       = c;
                rdata     = rsp_rdata;
                mis       = rsp_misaligned;
                req_valid = 1'b0;
            end else if (!hold) begin
                req_valid = 1'b0;
            end else begin
                req_addr  = $urandom;
                req_wdata = $urandom;
                req_write = 1'($urandom_range(0, 1));
                req_size  = 2'($urandom_range(0, 3));
            end
        end
        req_valid = 1'b0;
        check({tag, " rsp_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, rdata, exp_rdata);
        check({tag, " misaligned"}, 32'(mis), 32'(exp_mis));
        check({tag, " write_cycle"}, 32'(wcyc), 32'(exp_wcyc));
        if (exp_wcyc != 0) begin
            check({tag, " write_data"}, wword, exp_wword);
            check({tag, " write_addr"}, waddr, {addr[31:2], 2'b00});
        end
        @(negedge clk);
        check({tag, " rsp_valid_after"}, 32'(rsp_valid), 32'd0);
        check({tag, " rdata_hold"}, rsp_rdata, rdata);
        check({tag, " mis_hold"}, 32'(rsp_misaligned), 32'(mis));
        check({tag, " write_count"}, 32'(wr_count - wr0), (exp_wcyc != 0) ? 32'd1 : 32'd0);
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          hold;
        logic [31:0] exp_rdata;
        bit          exp_mis;
        int          exp_lat;
        int          exp_wcyc;
        logic [31:0] exp_wword;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m_rdata;
        logic [31:0] m_wword;
        bit          m_mis;
        int          m_lat;
        int          m_wcyc;
        int          wr0;

        //            wr size  uns addr    wdata          hold exp_rdata     mis lat wcyc wword
        tbl[0]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        1'b0, 32'hFFFFFF88, 1'b0, 2, 0, 32'h0};
        tbl[1]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        1'b0, 32'h00000088, 1'b0, 2, 0, 32'h0};
        tbl[2]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        1'b0, 32'hFFFF8899, 1'b0, 2, 0, 32'h0};
        tbl[3]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        1'b0, 32'h00008899, 1'b0, 2, 0, 32'h0};
        tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b0, 32'h8899AABB, 1'b0, 2, 0, 32'h0};
        tbl[5]  = '{1'b1, 2'd0, 1'b0, 32'h11, 32'h12345677, 1'b0, 32'h0,        1'b0, 3, 2, 32'h889977BB};
        tbl[6]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b0, 32'h889977BB, 1'b0, 2, 0, 32'h0};
        tbl[7]  = '{1'b1, 2'd2, 1'b0, 32'h14, 32'hDEADBEEF, 1'b1, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF};
        tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h14, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 2, 0, 32'h0};
        tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h12, 32'h0,        1'b0, 32'h0,        1'b1, 1, 0, 32'h0};
        tbl[10] = '{1'b1, 2'd1, 1'b0, 32'h11, 32'h0000BEEF, 1'b0, 32'h0,        1'b1, 1, 0, 32'h0};
        tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b0, 32'h889977BB, 1'b0, 2, 0, 32'h0};

        for (int i = 0; i < 256; i++) ref_bytes[i] = 8'h00;
        ref_bytes[8'h10] = 8'hBB;
        ref_bytes[8'h11] = 8'hAA;
        ref_bytes[8'h12] = 8'h99;
        ref_bytes[8'h13] = 8'h88;

        reset_n      = 1'b0;
        preload_req  = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        preload_req = 1'b0;
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset rsp_misaligned", 32'(rsp_misaligned), 32'd0);
        check("reset mem_write_enable", 32'(mem_write_enable), 32'd0);
        check("reset mem_address", mem_address, 32'd0);
        check("reset mem_write_data", mem_write_data, 32'd0);
        reset_n = 1'b1;

        // sh 0x12 with reset landing on the WRITE cycle: no write, no response.
        @(negedge clk);
        check("rstwr ready", 32'(req_ready), 32'd1);
        wr0          = wr_count;
        req_valid    = 1'b1;
        req_write    = 1'b1;
        req_size     = 2'd1;
        req_unsigned = 1'b0;
        req_addr     = 32'h12;
        req_wdata    = 32'h0000CAFE;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstwr read_cycle we", 32'(mem_write_enable), 32'd0);
        check("rstwr read_cycle busy", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("rstwr write_cycle we", 32'(mem_write_enable), 32'd1);
        check("rstwr merged word", mem_write_data, 32'hCAFEAABB);
        reset_n = 1'b0;
        #1;
        check("rstwr we gated", 32'(mem_write_enable), 32'd0);
        @(negedge clk);
        check("rstwr idle ready", 32'(req_ready), 32'd1);
        check("rstwr no rsp", 32'(rsp_valid), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstwr quiet rsp", 32'(rsp_valid), 32'd0);
        end
        check("rstwr write count", 32'(wr_count - wr0), 32'd0);

        for (int i = 0; i < 12; i++) begin
            ref_model(tbl[i].wr, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
                      m_rdata, m_mis, m_lat, m_wcyc, m_wword);
            run_txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].size, tbl[i].uns, tbl[i].addr,
                    tbl[i].wdata, tbl[i].hold, tbl[i].exp_rdata, tbl[i].exp_mis,
                    tbl[i].exp_lat, tbl[i].exp_wcyc, tbl[i].exp_wword);
        end

        for (int i = 0; i < 60; i++) begin
            bit          r_wr;
            logic [1:0]  r_size;
            bit          r_uns;
            logic [31:0] r_addr;
            logic [31:0] r_wdata;
            bit          r_hold;
            r_wr    = 1'($urandom_range(0, 1));
            r_size  = 2'($urandom_range(0, 3));
            r_uns   = 1'($urandom_range(0, 1));
            r_addr  = 32'($urandom_range(0, 255));
            r_wdata = $urandom;
            r_hold  = 1'($urandom_range(0, 1));
            ref_model(r_wr, r_size, r_uns, r_addr, r_wdata, m_rdata, m_mis, m_lat, m_wcyc, m_wword);
            run_txn($sformatf("rnd%0d", i), r_wr, r_size, r_uns, r_addr, r_wdata, r_hold,
                    m_rdata, m_mis, m_lat, m_wcyc, m_wword);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the core's execute stage and the word-addressed data memory. It accepts one RISC-V load or store request at a time (byte, halfword or word) and drives the memory's `address` / `write_data` / `write_enable` / `read_data` port. It performs lane extraction with sign or zero extension for loads and read-modify-write for sub-word stores. It detects misaligned accesses and reports them without touching memory.

## Interface
Parameters:
- none; memory geometry and data width come from `addr_t` / `data_t`.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset_n`  in  1  one clock; reset is synchronous and active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit idle; request accepted when `req_valid && req_ready`
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  `mem_size_t`: 00 byte, 01 half, 10 word, 11 illegal
- `req_unsigned`  in  1  zero-extend loads (lbu/lhu); ignored for word and stores
- `req_addr`  in  `addr_t`  byte address
- `req_wdata`  in  `data_t`  store data, right-aligned
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  `data_t`  extended load data; 0 for stores and misaligned
- `rsp_misaligned`  out  1  valid with `rsp_valid`
- `mem_address`  out  `addr_t`  to memory; word-aligned (bits [1:0] forced 0)
- `mem_write_data`  out  `data_t`  merged store word
- `mem_write_enable`  out  1  memory write strobe
- `mem_read_data`  in  `data_t`  combinational memory read of `mem_address`

## Operation
- FSM states: `IDLE`, `READ`, `WRITE`, `RESP`.
- `IDLE`
  - `req_ready=1`.
  - On accept, latch address, size, unsigned, write and wdata.
  - Misaligned → `RESP` with misaligned flag. Misaligned means half with addr[0]=1, word with addr[1:0]≠0, or size 11.
  - Load → `READ`.
  - Word store → `WRITE`.
  - Byte/half store → `READ`.
- `READ`: `mem_address` = latched address; register `mem_read_data` into word buffer. Load → `RESP`; sub-word store → `WRITE`.
- `WRITE`: `mem_write_enable=1` for exactly this cycle; `mem_write_data` = merged word → `RESP`.
- `RESP`: `rsp_valid=1` for one cycle → `IDLE`.
- Load extraction:
  - Byte lane = addr[1:0], half lane = addr[1].
  - Sign-extend bit 7/15 unless `req_unsigned`.
- Store merge:
  - Byte: replace bits [8k+7:8k] with wdata[7:0], k = addr[1:0].
  - Half: replace [16h+15:16h] with wdata[15:0], h = addr[1].
  - Other bytes come from the buffered read.
  - Word: wdata unchanged.
- `req_ready=0` in all states except `IDLE`. `req_valid` outside `IDLE` is ignored, not queued.

## Timing
- Accept at cycle N (edge ending N):
  - Load: `READ` N+1, `rsp_valid` N+2.
  - Word store: write N+1, response N+2.
  - Sub-word store: read N+1, write N+2, response N+3.
  - Misaligned: response N+1, no memory write.
- Back-to-back: the next request can be accepted in the cycle after `RESP`.
- Reset values: state `IDLE`, `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_misaligned=0`, `mem_write_enable=0`, `mem_address=0`, `mem_write_data=0`, all latched fields 0.
- `mem_write_enable` is gated by `reset_n`. Reset asserted in a `WRITE` cycle therefore issues no write.
- Reset mid-operation abandons the request; no response is produced.
- `rsp_rdata` and `rsp_misaligned` hold their last values outside `RESP`. Only `rsp_valid` qualifies them.

## Structure
- Shared package (with existing `addr_t` / `data_t`):
  - `mem_size_t` enum (`MEM_BYTE`, `MEM_HALF`, `MEM_WORD`)
  - FSM state enum `mau_state_t`
- Sub-module `mem_lane_align` (combinational): extraction/extension and store merge from addr[1:0], size and unsigned. Unit-testable alone.

## Test plan
All scenarios preload the memory word at 0x10 = 0x8899AABB.
- lb 0x13 → `rsp_rdata`=0xFFFFFF88 at N+2. lbu 0x13 → 0x00000088. `mem_write_enable` never asserted.
- lh 0x12 → 0xFFFF8899. lhu 0x12 → 0x00008899. lw 0x10 → 0x8899AABB.
- sb 0x11, wdata 0x12345677 → `mem_write_enable` high only at N+2 with `mem_write_data`=0x889977BB, `rsp_valid` at N+3. Readback lw 0x10 = 0x889977BB.
- sw 0x14, wdata 0xDEADBEEF → write at N+1, response at N+2, lw 0x14 = 0xDEADBEEF. `req_valid` held high during busy cycles → exactly one access.
- lw 0x12 and sh 0x11 → `rsp_misaligned=1` at N+1, `rsp_rdata`=0, no write, memory unchanged.
- sh 0x12, wdata 0x0000CAFE, with `reset_n` low during the `WRITE` cycle → no write, memory still 0x8899AABB. Next cycle is `IDLE` with `req_ready=1`, no `rsp_valid`.
